uart_tx: RTL and testbench

Transmit serializer of the AXI4-Lite UART. It pops bytes from the first-word-fall-through (FWFT) TX FIFO that the register block writes into. It serializes each byte onto the TX line using the frame format and baud rate from the CONFIG register. The frame format is start bit, 5–8 data bits LSB first, optional parity, and 1 or 2 stop bits.

---
 rtl/uart_pkg.sv | 64 ++++++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, TX state type and baud divider helper
//
// Contents:
//   uart_tx_state_t   TX frame state (IDLE, START, DATA, PARITY, STOP)
//   BAUD_*            3-bit baud select codes
//   DATA_BITS_*       2-bit data width codes (width = 5 + code)
//   STOP_BITS_*       stop bit count codes
//   PARITY_*          parity sense codes
//   baud_rate_hz()    baud select -> bit rate in Hz
//   baud_div()        clocks per bit, rounded to nearest (elaboration use)

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;
  localparam logic [2:0] BAUD_230400 = 3'd5;
  localparam logic [2:0] BAUD_460800 = 3'd6;
  localparam logic [2:0] BAUD_921600 = 3'd7;

  localparam logic [1:0] DATA_BITS_5 = 2'd0;
  localparam logic [1:0] DATA_BITS_6 = 2'd1;
  localparam logic [1:0] DATA_BITS_7 = 2'd2;
  localparam logic [1:0] DATA_BITS_8 = 2'd3;

  localparam logic STOP_BITS_1 = 1'b0;
  localparam logic STOP_BITS_2 = 1'b1;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic int unsigned baud_rate_hz(input logic [2:0] sel);
    int unsigned rate;
    case (sel)
      BAUD_9600:   rate = 9600;
      BAUD_19200:  rate = 19200;
      BAUD_38400:  rate = 38400;
      BAUD_57600:  rate = 57600;
      BAUD_115200: rate = 115200;
      BAUD_230400: rate = 230400;
      BAUD_460800: rate = 460800;
      default:     rate = 921600;
    endcase
    return rate;
  endfunction

  // Round to nearest so the bit time error is at most half a clock.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned rate;
    rate = baud_rate_hz(sel);
    return (clk_hz + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-time counter producing one tick per bit period
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   div       clocks per bit (must be >= 2)
//   restart   holds the counter at 0; released on the first clock of a bit
//   bit_done  single-cycle tick on the last clock of each bit (count == div-1)

module uart_baud_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W:0]   div,
  input  logic             restart,
  output logic             bit_done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   last;

  // div is one bit wider than the counter so a power-of-two divider still fits.
  assign last     = div - (CNT_W + 1)'(1);
  assign bit_done = ({1'b0, cnt} == last);

  // Wrapping at the end of each bit keeps every bit exactly div clocks long.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit serializer fed from a FWFT TX FIFO
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   i_fifo_empty  TX FIFO empty
//   i_fifo_data   TX FIFO head word, valid while !i_fifo_empty
//   o_fifo_rd_en  single-cycle pop strobe
//   i_baud_rate   baud select (uart_pkg BAUD_*)
//   i_data_bits   data width code, width = 5 + code
//   i_parity      0 even, 1 odd
//   i_use_parity  1 inserts a parity bit
//   i_stop_bits   0 one stop bit, 1 two stop bits
//   o_tx          serial line, idle high
//   o_busy        high while a frame is on the line

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_fifo_empty,
  input  logic [7:0] i_fifo_data,
  output logic       o_fifo_rd_en,
  input  logic [2:0] i_baud_rate,
  input  logic [1:0] i_data_bits,
  input  logic       i_parity,
  input  logic       i_use_parity,
  input  logic       i_stop_bits,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int unsigned DIV_0 = baud_div(CLK_FREQ_HZ, BAUD_9600);
  localparam int unsigned DIV_1 = baud_div(CLK_FREQ_HZ, BAUD_19200);
  localparam int unsigned DIV_2 = baud_div(CLK_FREQ_HZ, BAUD_38400);
  localparam int unsigned DIV_3 = baud_div(CLK_FREQ_HZ, BAUD_57600);
  localparam int unsigned DIV_4 = baud_div(CLK_FREQ_HZ, BAUD_115200);
  localparam int unsigned DIV_5 = baud_div(CLK_FREQ_HZ, BAUD_230400);
  localparam int unsigned DIV_6 = baud_div(CLK_FREQ_HZ, BAUD_460800);
  localparam int unsigned DIV_7 = baud_div(CLK_FREQ_HZ, BAUD_921600);

  // Slowest baud gives the largest divider; the fastest gives the smallest.
  localparam int CNT_W = $clog2(DIV_0);
  localparam int DIV_W = CNT_W + 1;

  if (DIV_7 < 2) begin : g_div_too_small
    $error("uart_tx: CLK_FREQ_HZ too low, fastest baud divider is below 2");
  end

  uart_tx_state_t   state, state_next;
  logic             pop;
  logic             bit_done;
  logic             last_data;
  logic             frame_end;
  logic [DIV_W-1:0] sel_div;

  logic [DIV_W-1:0] div_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt;
  logic             stop_cnt;
  logic             parity_acc;
  logic [1:0]       data_bits_q;
  logic             parity_odd_q;
  logic             use_parity_q;
  logic             stop_bits_q;

  always_comb begin
    sel_div = DIV_W'(DIV_0);
    case (i_baud_rate)
      BAUD_19200:  sel_div = DIV_W'(DIV_1);
      BAUD_38400:  sel_div = DIV_W'(DIV_2);
      BAUD_57600:  sel_div = DIV_W'(DIV_3);
      BAUD_115200: sel_div = DIV_W'(DIV_4);
      BAUD_230400: sel_div = DIV_W'(DIV_5);
      BAUD_460800: sel_div = DIV_W'(DIV_6);
      BAUD_921600: sel_div = DIV_W'(DIV_7);
      default:     sel_div = DIV_W'(DIV_0);
    endcase
  end

  // Held in reset while idle so the start bit always begins at count 0.
  uart_baud_gen #(
    .CNT_W (CNT_W)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .div      (div_q),
    .restart  (state == IDLE),
    .bit_done (bit_done)
  );

  // Last data bit index is N-1 = 4 + data width code.
  assign last_data = (bit_cnt == (3'd4 + {1'b0, data_bits_q}));
  assign frame_end = (state == STOP) && bit_done && (stop_cnt == stop_bits_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!i_fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        if (bit_done && last_data) state_next = use_parity_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
      STOP: begin
        if (frame_end) begin
          // Back-to-back: the next start bit follows the final stop bit directly.
          if (!i_fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) pop = 1'b0;
  end

  always_comb begin
    o_tx         = 1'b1;
    o_busy       = 1'b0;
    o_fifo_rd_en = pop;
    case (state)
      START: begin
        o_tx   = 1'b0;
        o_busy = 1'b1;
      end
      DATA: begin
        o_tx   = shift_q[0];
        o_busy = 1'b1;
      end
      PARITY: begin
        o_tx   = parity_acc ^ (parity_odd_q == PARITY_ODD);
        o_busy = 1'b1;
      end
      STOP: begin
        o_busy = 1'b1;
      end
      default: begin
        o_tx   = 1'b1;
        o_busy = 1'b0;
      end
    endcase
  end

  // Frame configuration is captured at the pop and held for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      shift_q      <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      parity_acc   <= 1'b0;
      data_bits_q  <= DATA_BITS_5;
      parity_odd_q <= PARITY_EVEN;
      use_parity_q <= 1'b0;
      stop_bits_q  <= STOP_BITS_1;
    end else if (pop) begin
      div_q        <= sel_div;
      shift_q      <= i_fifo_data;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      parity_acc   <= 1'b0;
      data_bits_q  <= i_data_bits;
      parity_odd_q <= i_parity;
      use_parity_q <= i_use_parity;
      stop_bits_q  <= i_stop_bits;
    end else if (bit_done) begin
      case (state)
        DATA: begin
          // Only bits actually sent reach the accumulator.
          shift_q    <= {1'b0, shift_q[7:1]};
          parity_acc <= parity_acc ^ shift_q[0];
          bit_cnt    <= bit_cnt + 3'd1;
        end
        STOP: begin
          stop_cnt <= stop_cnt + 1'b1;
        end
        default: begin
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx

module tb_uart_tx;

  // Fastest select (7) gives DIV = 10; select 6 gives DIV = 20; slowest is 960.
  localparam int CLK_HZ = 9_216_000;

  typedef struct {
    int          nbits;
    logic [11:0] bits;   // line level per bit, bit 0 = start bit
    int          div;
    bit          b2b;    // frame must start straight after the previous one
  } exp_frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_fifo_empty = 1'b1;
  logic [7:0] i_fifo_data = 8'h00;
  logic       o_fifo_rd_en;
  logic [2:0] i_baud_rate = 3'd7;
  logic [1:0] i_data_bits = 2'd3;
  logic       i_parity = 1'b0;
  logic       i_use_parity = 1'b0;
  logic       i_stop_bits = 1'b0;
  logic       o_tx;
  logic       o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int pops = 0;
  int empty_pops = 0;
  int n_pushed = 0;
  int cyc = 0;
  bit mon_active = 0;

  logic [7:0] fifo_q[$];
  exp_frame_t exp_q[$];

  uart_tx #(
    .CLK_FREQ_HZ (CLK_HZ)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd_en (o_fifo_rd_en),
    .i_baud_rate  (i_baud_rate),
    .i_data_bits  (i_data_bits),
    .i_parity     (i_parity),
    .i_use_parity (i_use_parity),
    .i_stop_bits  (i_stop_bits),
    .o_tx         (o_tx),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FWFT FIFO model
  always @(posedge clk) begin
    if (o_fifo_rd_en) begin
      if (i_fifo_empty) empty_pops++;
      else begin
        void'(fifo_q.pop_front());
        pops++;
      end
    end
    i_fifo_empty <= (fifo_q.size() == 0);
    i_fifo_data  <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic set_cfg(input logic [2:0] baud, input logic [1:0] bits,
                         input logic par, input logic use_par, input logic stop);
    i_baud_rate  = baud;
    i_data_bits  = bits;
    i_parity     = par;
    i_use_parity = use_par;
    i_stop_bits  = stop;
  endtask

  task automatic send(input logic [7:0] b, input int nbits, input logic [11:0] bits,
                      input int div, input bit b2b);
    exp_frame_t e;
    e.nbits = nbits;
    e.bits  = bits;
    e.div   = div;
    e.b2b   = b2b;
    exp_q.push_back(e);
    fifo_q.push_back(b);
    n_pushed++;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    @(posedge clk);
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || mon_active || o_busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: got still busy after %0d cycles, required idle", name, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input int p0, input int budget, input string name);
    int n = 0;
    while (pops == p0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (pops == p0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pop_timeout_%s: got no pop in %0d cycles, required a pop", name, n);
    end
  endtask

  // Monitor: on each pop, take the next expected frame and check the line bit by bit.
  initial begin : monitor
    exp_frame_t e;
    bit   have_pop = 0;
    bit   aborted;
    bit   bad;
    bit   last;
    logic bad_tx, bad_busy;
    int   start_c = 0;
    int   prev_start = 0;
    int   prev_len = 0;
    int   frame_no = 0;
    forever begin
      while (!have_pop) begin
        @(negedge clk);
        if (o_fifo_rd_en) have_pop = 1;
      end
      have_pop = 0;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got a pop at cycle %0d, required none", cyc);
        continue;
      end
      e = exp_q.pop_front();
      mon_active = 1;
      aborted = 0;
      for (int k = 0; k < e.nbits; k++) begin
        bad = 0;
        bad_tx = 1'b0;
        bad_busy = 1'b0;
        for (int c = 0; c < e.div; c++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          if (k == 0 && c == 0) start_c = cyc;
          last = (k == e.nbits - 1) && (c == e.div - 1);
          if (!bad && (o_tx !== e.bits[k] || o_busy !== 1'b1 || (o_fifo_rd_en && !last))) begin
            bad = 1;
            bad_tx = o_tx;
            bad_busy = o_busy;
          end
          if (o_fifo_rd_en && last) have_pop = 1;
        end
        if (aborted) break;
        n_cmp++;
        if (bad) begin
          n_bad++;
          $display("FAIL frame_bit f=%0d bit=%0d: got tx=%b busy=%b (or stray pop), required tx=%b busy=1 no pop",
                   frame_no, k, bad_tx, bad_busy, e.bits[k]);
        end
      end
      if (!aborted) begin
        if (e.b2b) check($sformatf("b2b_start_gap f=%0d", frame_no), start_c - prev_start, prev_len);
        prev_start = start_c;
        prev_len = e.nbits * e.div;
        if (!have_pop) begin
          @(negedge clk);
          n_cmp++;
          if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after f=%0d: got tx=%b busy=%b, required tx=1 busy=0", frame_no, o_tx, o_busy);
          end
          if (o_fifo_rd_en) have_pop = 1;
        end
      end
      frame_no++;
      mon_active = 0;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2 ms, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int p0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_tx", int'(o_tx), 1);
    check("reset_busy", int'(o_busy), 0);
    check("reset_rd_en", int'(o_fifo_rd_en), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 8N1 0x55
    set_cfg(3'd7, 2'd3, 1'b0, 1'b0, 1'b0);
    send(8'h55, 10, 12'h2AA, 10, 0);
    wait_done(400, "8n1_55");

    // 7E1 0x41 -> data 1000001, parity 0
    set_cfg(3'd7, 2'd2, 1'b0, 1'b1, 1'b0);
    send(8'h41, 10, 12'h282, 10, 0);
    wait_done(400, "7e1_41");

    // 7O1 0x41 -> parity 1
    set_cfg(3'd7, 2'd2, 1'b1, 1'b1, 1'b0);
    send(8'h41, 10, 12'h382, 10, 0);
    wait_done(400, "7o1_41");

    // 7E1 0xC1 at select 6: bit 7 ignored, same frame at DIV=20
    set_cfg(3'd6, 2'd2, 1'b0, 1'b1, 1'b0);
    send(8'hC1, 10, 12'h282, 20, 0);
    wait_done(600, "7e1_c1");

    // 5N2 0xFF -> 80 clocks
    set_cfg(3'd7, 2'd0, 1'b0, 1'b0, 1'b1);
    send(8'hFF, 8, 12'h0FE, 10, 0);
    wait_done(400, "5n2_ff");

    // Back-to-back 0xA5, 0x3C
    set_cfg(3'd7, 2'd3, 1'b0, 1'b0, 1'b0);
    p0 = pops;
    send(8'hA5, 10, 12'h34A, 10, 0);
    send(8'h3C, 10, 12'h278, 10, 1);
    wait_done(600, "b2b");
    check("b2b_pop_count", pops - p0, 2);

    // Width change mid-frame: first frame 8 bits, second 5 bits
    p0 = pops;
    send(8'h96, 10, 12'h32C, 10, 0);
    send(8'h2B, 7, 12'h056, 10, 1);
    wait_pop(p0, 50, "cfg_change");
    repeat (20) @(posedge clk);
    #1 i_data_bits = 2'd0;
    wait_done(600, "cfg_change");

    // Reset during DATA with another byte waiting
    set_cfg(3'd7, 2'd3, 1'b0, 1'b0, 1'b0);
    p0 = pops;
    send(8'h0F, 10, 12'h21E, 10, 0);
    wait_pop(p0, 50, "rst_frame");
    repeat (35) @(posedge clk);
    #1;
    send(8'h33, 10, 12'h266, 10, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_tx", int'(o_tx), 1);
    check("rst_mid_busy", int'(o_busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold_no_pop %0d", i), int'(o_fifo_rd_en), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done(600, "after_rst");
    check("rst_pop_count", pops - p0, 2);

    check("total_pops", pops, n_pushed);
    check("empty_pops", empty_pops, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
